// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost flags, run-time circular replay
// and selectable first-word-fallthrough. Sticky overflow/underflow only with FIFO_ERR_FLAGS_EN.
module fifo_param #(
  parameter int WIDTH                 = 32,
  parameter int DEPTH                 = 4,
  parameter int FIRSTWORD_FALLTHROUGH = 1,
  parameter int AFULL_LVL             = DEPTH - 1,
  parameter int AEMPTY_LVL            = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       circular,
  input  logic                       write,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       read,
  output logic [WIDTH-1:0]           dataout,
  output logic                       valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wp_reg, wp_next;
  logic [PW-1:0] hp_reg, hp_next;
  logic [PW-1:0] rp_reg, rp_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] last_ptr;
  logic [PW-1:0] rd_addr;
  logic          rd_ok, wr_ok, ovw;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= CW'(AFULL_LVL));
  assign almost_empty = (count_reg <= CW'(AEMPTY_LVL));
  assign count        = count_reg;

  // Newest stored entry, used by replay to know when to wrap back to the head.
  assign last_ptr = (wp_reg == '0) ? PW'(DEPTH - 1) : wp_reg - PW'(1);
  assign rd_addr  = circular ? rp_reg : hp_reg;

  always_comb begin
    rd_ok      = read && !empty;
    ovw        = circular && full && write;
    wr_ok      = write && (!full || circular || rd_ok);
    wp_next    = wr_ok ? inc(wp_reg) : wp_reg;
    hp_next    = hp_reg;
    count_next = count_reg;
    rp_next    = rp_reg;

    if ((!circular && rd_ok) || ovw)
      hp_next = inc(hp_reg);

    if (circular) begin
      if (wr_ok && !full)
        count_next = count_reg + CW'(1);
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end

    // Outside replay the replay pointer follows the head, which also performs the
    // reload on the edge where circular drops.
    if (!circular)
      rp_next = hp_next;
    else if (rd_ok)
      rp_next = (!full && rp_reg == last_ptr) ? hp_reg : inc(rp_reg);
    else if (ovw && rp_reg == hp_reg)
      rp_next = hp_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_reg    <= '0;
      hp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      wp_reg    <= wp_next;
      hp_reg    <= hp_next;
      rp_reg    <= rp_next;
      count_reg <= count_next;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok)
      mem[wp_reg] <= datain;
  end

  generate
    if (FIRSTWORD_FALLTHROUGH != 0) begin : g_fwft
      assign dataout = empty ? '0 : mem[rp_reg];
      assign valid   = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_reg;
      logic             valid_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= rd_ok;
          if (rd_ok)
            dout_reg <= mem[rd_addr];
        end
      end
      assign dataout = dout_reg;
      assign valid   = valid_reg;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (write && !wr_ok)
        overflow_reg <= 1'b1;
      if (read && !rd_ok)
        underflow_reg <= 1'b1;
    end
  end
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: FWFT instance (a) and registered-read instance (b).
// Error-flag checks are compiled only when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, circ;
  logic        write_a, read_a, write_b, read_b;
  logic [31:0] datain_a, datain_b;
  logic [31:0] dataout_a, dataout_b;
  logic        valid_a, full_a, empty_a, afull_a, aempty_a;
  logic        valid_b, full_b, empty_b, afull_b, aempty_b;
  logic [2:0]  count_a, count_b;
`ifdef FIFO_ERR_FLAGS_EN
  logic        ovf_a, udf_a, ovf_b, udf_b;
`endif

  fifo_param #(.WIDTH(32), .DEPTH(4), .FIRSTWORD_FALLTHROUGH(1)) dut_a (
    .clk(clk), .reset(reset), .circular(circ), .write(write_a), .datain(datain_a),
    .read(read_a), .dataout(dataout_a), .valid(valid_a), .full(full_a), .empty(empty_a),
    .almost_full(afull_a), .almost_empty(aempty_a), .count(count_a)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf_a), .underflow(udf_a)
`endif
  );

  fifo_param #(.WIDTH(32), .DEPTH(4), .FIRSTWORD_FALLTHROUGH(0)) dut_b (
    .clk(clk), .reset(reset), .circular(1'b0), .write(write_b), .datain(datain_b),
    .read(read_b), .dataout(dataout_b), .valid(valid_b), .full(full_b), .empty(empty_b),
    .almost_full(afull_b), .almost_empty(aempty_b), .count(count_b)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf_b), .underflow(udf_b)
`endif
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ea, eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Level and flags of instance a: {full, empty, almost_full, almost_empty}.
  task automatic st(input string tag, input int c, input logic [3:0] flags);
    chk({tag, "_count"}, 32'(count_a), 32'(c));
    chk({tag, "_flags"}, {28'd0, full_a, empty_a, afull_a, aempty_a}, {28'd0, flags});
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic r);
    write_a = w; datain_a = d; read_a = r;
    @(posedge clk); #1;
    write_a = 1'b0; read_a = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic rd(input logic [31:0] e);
    qa.push_back(e);
    step(1'b0, 32'd0, 1'b1);
  endtask

  task automatic rw(input logic [31:0] d, input logic [31:0] e);
    qa.push_back(e);
    step(1'b1, d, 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(1'b0, 32'd0, 1'b0);
    reset = 1'b0;
  endtask

  // Monitor: a consumes on read while valid; b presents a word while valid.
  always @(negedge clk) begin
    if (!reset && read_a && valid_a) begin
      if (qa.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL a_pop: got 0x%0h, expected no read data", dataout_a);
      end else begin
        ea = qa.pop_front();
        chk("a_pop", dataout_a, ea);
      end
    end
    if (!reset && valid_b) begin
      if (qb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_pop: got 0x%0h, expected no read data", dataout_b);
      end else begin
        eb = qb.pop_front();
        chk("b_pop", dataout_b, eb);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] replay_seq [3];

  initial begin
    reset = 1'b1; circ = 1'b0;
    write_a = 1'b0; read_a = 1'b0; datain_a = '0;
    write_b = 1'b0; read_b = 1'b0; datain_b = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    st("rst", 0, 4'b0101);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_dout_a", dataout_a, 0);
    chk("rst_valid_b", valid_b, 0);
    chk("rst_dout_b", dataout_b, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", ovf_a, 0);
    chk("rst_udf", udf_a, 0);
`endif

    // Fill
    wr(32'h9); st("w1", 1, 4'b0001); chk("w1_dout", dataout_a, 32'h9); chk("w1_valid", valid_a, 1);
    wr(32'h1); st("w2", 2, 4'b0000);
    wr(32'h2); st("w3", 3, 4'b0010);
    wr(32'h3); st("w4", 4, 4'b1010); chk("w4_dout", dataout_a, 32'h9);

    // Overflow then drain
    wr(32'h4); st("ovw", 4, 4'b1010);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovw_ovf", ovf_a, 1);
    chk("ovw_udf", udf_a, 0);
`endif
    rd(32'h9); rd(32'h1); rd(32'h2); rd(32'h3);
    st("drain", 0, 4'b0101);
    chk("drain_valid", valid_a, 0);
    step(1'b0, 32'd0, 1'b1);
    st("udf", 0, 4'b0101);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_udf", udf_a, 1);
`endif

    // Read+write while full
    wr(32'h11); wr(32'h12); wr(32'h13); wr(32'h14);
    rw(32'hA, 32'h11); st("rwf1", 4, 4'b1010);
    rw(32'hB, 32'h12); st("rwf2", 4, 4'b1010);
    rw(32'hC, 32'h13); st("rwf3", 4, 4'b1010);
    rd(32'h14); rd(32'hA); rd(32'hB); rd(32'hC);
    st("rwf_drain", 0, 4'b0101);

    // Read+write while empty
    pulse_reset();
    step(1'b1, 32'h5, 1'b1);
    st("rwe", 1, 4'b0001);
    chk("rwe_dout", dataout_a, 32'h5);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rwe_udf", udf_a, 1);
    chk("rwe_ovf", ovf_a, 0);
`endif
    rd(32'h5);

    // Circular replay
    replay_seq[0] = 32'hA; replay_seq[1] = 32'hE; replay_seq[2] = 32'h47F;
    wr(32'hA); wr(32'hE); wr(32'h47F);
    st("rep_fill", 3, 4'b0010);
    circ = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rd(replay_seq[i % 3]);
      chk("rep_count", 32'(count_a), 3);
    end
    chk("rep_next", dataout_a, 32'hE);
    circ = 1'b0;
    step(1'b0, 32'd0, 1'b0);
    chk("rep_reload", dataout_a, 32'hA);
    rd(32'hA);
    st("rep_pop", 2, 4'b0000);
    rd(32'hE); rd(32'h47F);
    st("rep_drain", 0, 4'b0101);

    // Circular overwrite
    pulse_reset();
    wr(32'h1); wr(32'h2); wr(32'h3); wr(32'h4);
    circ = 1'b1;
    wr(32'h5);
    st("cov", 4, 4'b1010);
    chk("cov_head", dataout_a, 32'h2);
`ifdef FIFO_ERR_FLAGS_EN
    chk("cov_ovf", ovf_a, 0);
`endif
    rd(32'h2); rd(32'h3); rd(32'h4); rd(32'h5); rd(32'h2);
    st("cov_replay", 4, 4'b1010);
    circ = 1'b0;
    step(1'b0, 32'd0, 1'b0);

    // Registered-read instance
    pulse_reset();
    write_b = 1'b1; datain_b = 32'h7;
    @(posedge clk); #1;
    write_b = 1'b0;
    chk("b_wr_valid", valid_b, 0);
    chk("b_wr_count", 32'(count_b), 1);
    read_b = 1'b1; qb.push_back(32'h7);
    @(posedge clk); #1;
    read_b = 1'b0;
    chk("b_rd_valid", valid_b, 1);
    chk("b_rd_dout", dataout_b, 32'h7);
    @(posedge clk); #1;
    chk("b_idle_valid", valid_b, 0);
    chk("b_idle_dout", dataout_b, 32'h7);
    chk("b_idle_count", 32'(count_b), 0);

    // Reset mid-operation overrides read+write
    wr(32'h21); wr(32'h22);
    st("mid_pre", 2, 4'b0000);
    reset = 1'b1;
    step(1'b1, 32'h23, 1'b1);
    reset = 1'b0;
    st("mid_rst", 0, 4'b0101);
    chk("mid_valid", valid_a, 0);
    chk("mid_dout", dataout_a, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mid_ovf", ovf_a, 0);
    chk("mid_udf", udf_a, 0);
`endif
    step(1'b0, 32'd0, 1'b0);

    chk("a_queue_left", qa.size(), 0);
    chk("b_queue_left", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised single-clock FIFO, the successor to the fixed-width `fifo`. It adds a configurable data width, a fill-level output, programmable almost-full and almost-empty flags, and a circular replay mode that can be switched at run time. First-word-fallthrough is selectable per instance. It sits between producer and consumer blocks inside one clock domain, wherever the old `fifo` was used.

## Interface
- `WIDTH`, 32, data word width in bits (≥1)
- `DEPTH`, 4, number of entries (≥2; need not be a power of two)
- `FIRSTWORD_FALLTHROUGH`, 1, 1 = head word shown on `dataout` without a read; 0 = registered read, 1-cycle latency
- `AFULL_LVL`, DEPTH-1, `almost_full` asserts when `count` ≥ this value
- `AEMPTY_LVL`, 1, `almost_empty` asserts when `count` ≤ this value
- `clk`  in  1  sole clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `circular`  in  1  1 = replay mode (reads do not consume; writes to a full FIFO overwrite the oldest entry)
- `write`  in  1  write request
- `datain`  in  WIDTH  write data
- `read`  in  1  read request
- `dataout`  out  WIDTH  read data
- `valid`  out  1  `dataout` holds a valid word
- `full`  out  1  `count` == DEPTH
- `empty`  out  1  `count` == 0
- `almost_full`  out  1  see `AFULL_LVL`
- `almost_empty`  out  1  see `AEMPTY_LVL`
- `count`  out  $clog2(DEPTH+1)  current number of stored entries
- `overflow`  out  1  sticky error flag; present only with `FIFO_ERR_FLAGS_EN`
- `underflow`  out  1  sticky error flag; present only with `FIFO_ERR_FLAGS_EN`

## Operation
- **State:** memory of `DEPTH` entries, plus three pointers in 0..DEPTH-1:
  - write pointer `wp`
  - head pointer `hp` (oldest entry)
  - replay pointer `rp`
- **Pointer wrap:** each pointer wraps from DEPTH-1 to 0.
- **Normal mode (`circular`=0):**
  - Write when not full: stores at `wp`, increments `wp` and `count`.
  - Read when not empty: pops the entry at `hp`, increments `hp`, decrements `count`.
  - `rp` tracks `hp`.
- **Write when full (normal):** ignored, memory unchanged, flags overflow.
- **Read when empty:** ignored, flags underflow.
- **Simultaneous read and write:**
  - When full: both proceed and `count` is unchanged.
  - When empty: the write proceeds and the read is an underflow.
- **Circular mode (`circular`=1):**
  - A read returns the entry at `rp` and advances `rp`. When `rp` passes the newest entry it wraps to `hp`.
  - `count` and `hp` are unchanged by reads.
  - Read when empty is an underflow.
- **Write in circular mode:**
  - Not full: normal append.
  - Full: writes at `wp` (== `hp`), advances `wp` and `hp`, keeps `count` == DEPTH, and is not an overflow.
  - If `rp` equalled the old `hp`, it moves to the new `hp`.
- **Mode change:** a 1→0 transition of `circular` reloads `rp` ← `hp` on that edge. Replayed entries are then popped normally from the oldest entry.
- **Flags:** `full`, `empty`, `almost_full`, `almost_empty` are decoded from registered `count`.

## Timing
- **Reset:** in effect on the edge where `reset`=1; it overrides all requests on that edge. Afterwards:
  - pointers = 0, `count` = 0
  - `dataout` = 0, `valid` = 0
  - `empty` = 1, `almost_empty` = 1
  - `full` = 0, `almost_full` = 0 (unless `AFULL_LVL` = 0)
  - `overflow` = `underflow` = 0
  - Memory contents are not cleared.
- **Write visibility:** a write accepted at edge N is reflected in `count` and the flags from edge N.
- **FWFT = 1:**
  - `dataout` = mem[`rp`] whenever not empty; `valid` = !`empty`.
  - A write into an empty FIFO at edge N gives `valid` = 1 with that word from edge N.
  - A read at edge N presents the next word from edge N.
- **FWFT = 0:**
  - A read accepted at edge N loads `dataout` at edge N and sets `valid` = 1 for the following cycle.
  - `valid` = 0 after any edge with no accepted read; `dataout` holds its last value.
- **Throughput:** one accepted read and one accepted write per cycle, with no bubbles.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on a rejected write; `underflow` sets on a rejected read.
  - Both stay set until `reset`.
- `FIFO_ERR_FLAGS_EN` undefined:
  - `overflow` and `underflow` ports and logic are absent.
  - Rejected requests are silently ignored.

## Test plan
Unless noted: WIDTH = 32, DEPTH = 4, FWFT = 1, default levels.
- **Reset then fill:** reset; write 0x9, 0x1, 0x2, 0x3 on consecutive cycles → `count` steps 1..4, `full` = 1 after the 4th edge, `almost_full` = 1 after the 3rd, `dataout` = 0x9 from the 1st edge.
- **Overflow and drain:** write 0x4 while full → ignored, `overflow` = 1 (macro defined); read 4 times → `dataout` 0x9, 0x1, 0x2, 0x3, then `empty` = 1. A 5th read sets `underflow` = 1.
- **Simultaneous read and write:**
  - Full: read + write for 3 cycles with data 0xA, 0xB, 0xC → `count` stays 4, popped data in order.
  - Empty: read + write of 0x5 → `count` = 1, `underflow` = 1.
- **Circular replay:** write 0xA, 0xE, 0x47F; set `circular`; read 7 cycles → `dataout` 0xA, 0xE, 0x47F, 0xA, 0xE, 0x47F, 0xA with `count` = 3 throughout. Clear `circular`, read → 0xA popped, `count` = 2.
- **Circular overwrite:** full with 1, 2, 3, 4, `circular` = 1; write 5 → `count` = 4, no overflow, replay sequence 2, 3, 4, 5.
- **FWFT = 0 and reset mid-operation:**
  - FWFT = 0: write 0x7, read at edge N → `dataout` = 0x7 and `valid` = 1 for one cycle after edge N.
  - Assert `reset` with `count` = 2 and read + write high → after the edge `count` = 0, `valid` = 0, flags cleared.
